// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - system handshake and SPI pins of spi_master
interface spi_master_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  start;
  logic [DATA_WIDTH-1:0] masterDataToSend;
  logic [DATA_WIDTH-1:0] masterDataReceived;
  logic                  busy;
  logic                  done;
  logic                  sclk;
  logic                  CS;
  logic                  MOSI;
  logic                  MISO;

  modport master (
    input  start, masterDataToSend, MISO,
    output masterDataReceived, busy, done, sclk, CS, MOSI
  );

  modport slave (
    output start, masterDataToSend, MISO,
    input  masterDataReceived, busy, done, sclk, CS, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master, one word per start strobe
// SPI_MASTER_LOOPBACK_EN: rx samples internal MOSI instead of the MISO pin
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input logic          clk,
  input logic          reset,
  spi_master_if.master bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BITS     = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER_HI, XFER_LO, HOLD, GAP} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rx_bit;
  logic                  div_last;
  logic [DATA_WIDTH-1:0] rx_shift;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = bus.MISO;
  assign rx_bit      = mosi_q;
`else
  assign rx_bit      = bus.MISO;
`endif

  assign div_last = (div_q == DIV_LAST);
  assign rx_shift = {rx_q[DATA_WIDTH-2:0], rx_bit};

  always_comb begin
    state_d = state_q;
    div_d   = (state_q == IDLE || div_last) ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_d    = bus.masterDataToSend;
          mosi_d  = bus.masterDataToSend[DATA_WIDTH-1];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_last) begin
          sclk_d  = 1'b1;
          rx_d    = rx_shift;
          state_d = XFER_HI;
        end
      end
      XFER_HI: begin
        if (div_last) begin
          sclk_d  = 1'b0;
          bit_d   = bit_q + 1'b1;
          state_d = XFER_LO;
          // The last bit stays on MOSI through the trailing low half-period.
          if (bit_q != LAST_BIT) begin
            tx_d   = tx_q << 1;
            mosi_d = tx_q[DATA_WIDTH-2];
          end
        end
      end
      XFER_LO: begin
        if (div_last) begin
          if (bit_q == BITS) begin
            state_d = HOLD;
          end else begin
            sclk_d  = 1'b1;
            rx_d    = rx_shift;
            state_d = XFER_HI;
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          rdata_d = rx_q;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (div_last) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.masterDataReceived = rdata_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.sclk               = sclk_q;
  assign bus.CS                 = cs_q;
  assign bus.MOSI               = mosi_q;
endmodule
